// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender: inhibit, start bit, 8 data + odd parity + stop, device ACK.
// Latency: INHIBIT_CYCLES+1 cycles of clock inhibit, then paced by the device clock; tx_ready only in IDLE.
// Define PS2_TX_FILTER_EN to add an 8-sample glitch filter on the sensed clock (8 cycles more edge latency).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] clk_sync, data_sync;
    logic       clk_line, clk_prev, data_line, fe;
    logic       accept, tmo;
    logic [7:0] data_q;
    logic       parity_q;
    logic [3:0] bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic       data_drive;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
        end
    end

    assign data_line = data_sync[1];

`ifdef PS2_TX_FILTER_EN
    logic       clk_filt;
    logic [2:0] filt_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= 3'd0;
        end else if (clk_sync[1] == clk_filt) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == 3'd7) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= 3'd0;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign clk_line = clk_filt;
`else
    assign clk_line = clk_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) clk_prev <= 1'b1;
        else        clk_prev <= clk_line;
    end

    assign fe  = clk_prev & ~clk_line;
    assign tmo = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        tx_ready    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    accept    = 1'b1;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_nxt = REQ;
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                ps2_data_oe = data_drive;
                if (tmo) begin
                    tx_err    = 1'b1;
                    state_nxt = IDLE;
                end else if (fe && bit_cnt == 4'd9) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (tmo) begin
                    tx_err    = 1'b1;
                    state_nxt = IDLE;
                end else if (fe) begin
                    if (data_line) begin
                        tx_err    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Timeout wins so done and err can never coincide.
                if (tmo) begin
                    tx_err    = 1'b1;
                    state_nxt = IDLE;
                end else if (clk_line && data_line) begin
                    tx_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= 8'd0;
            parity_q   <= 1'b0;
            bit_cnt    <= 4'd0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            data_drive <= 1'b0;
        end else begin
            if (accept) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
                bit_cnt  <= 4'd0;
                inh_cnt  <= '0;
                tmo_cnt  <= '0;
            end
            if (state == INHIBIT) inh_cnt <= inh_cnt + INH_W'(1);
            if (state == REQ) data_drive <= 1'b1;
            if (state == SHIFT || state == ACK || state == WAIT_IDLE) tmo_cnt <= tmo_cnt + TMO_W'(1);
            // Host changes data while the device holds clock low; oe is the inverse of the line level.
            if (state == SHIFT && fe) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt < 4'd8)       data_drive <= ~data_q[bit_cnt[2:0]];
                else if (bit_cnt == 4'd8) data_drive <= ~parity_q;
                else                      data_drive <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on open-drain lines with a frame/result scoreboard.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_done, tx_err;
    logic       kbd_clk_low = 1'b0;
    logic       kbd_data_low = 1'b0;

    always #5 clk = ~clk;

    assign ps2_clk_i  = ~(ps2_clk_oe | kbd_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | kbd_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    int checks = 0;
    int passed = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_cycles = 0;

    logic [9:0] exp_frame_q[$];
    bit         exp_ack_q[$];

    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe) oe_cycles <= oe_cycles + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one request and records what the keyboard should see and whether it will ACK.
    task automatic send(input logic [7:0] d, input bit ack);
        int k = 0;
        while (!tx_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_frame_q.push_back({1'b1, ~^d, d});
        exp_ack_q.push_back(ack);
    endtask

    // Keyboard: waits for request-to-send, clocks 11 falling edges, samples data on each rising edge.
    task automatic kbd(input bit ack, output logic [9:0] frame, output bit started);
        int k = 0;
        frame = '0;
        while (!(!ps2_clk_oe && ps2_data_oe) && k < INH + 100) begin
            @(negedge clk);
            k++;
        end
        started = !ps2_clk_oe && ps2_data_oe;
        if (started) begin
            wait_cycles(H);
            for (int i = 0; i < 11; i++) begin
                kbd_clk_low = 1'b1;
                wait_cycles(H);
                kbd_clk_low = 1'b0;
                if (i < 10) frame[i] = ps2_data_i;
                if (i == 9 && ack) kbd_data_low = 1'b1;
                if (i == 10) kbd_data_low = 1'b0;
                wait_cycles(H);
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        wait_cycles(3);
        checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else passed++;
        checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else passed++;
        checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else passed++;
        checks++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", tx_done); else passed++;
        checks++; if (tx_err !== 1'b0) $display("FAIL reset_tx_err: got %b want 0", tx_err); else passed++;
        rst_n = 1'b1;
        wait_cycles(5);
        checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) $display("FAIL post_reset_idle: ready=%b clk_oe=%b want 1/0", tx_ready, ps2_clk_oe); else passed++;
    endtask

    task automatic test_inhibit;
        int n = 0, first_data = -1, k = 0;
        logic [9:0] got, exp;
        bit st, exp_ack;
        send(8'h55, 1'b1);
        fork
            begin
                while (!ps2_clk_oe && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                while (ps2_clk_oe && n < INH + 100) begin
                    if (ps2_data_oe && first_data < 0) first_data = n;
                    n++;
                    @(negedge clk);
                end
            end
            kbd(1'b1, got, st);
        join
        wait_cycles(20);
        exp = exp_frame_q.pop_front();
        exp_ack = exp_ack_q.pop_front();
        checks++; if (n !== INH + 1) $display("FAIL inhibit_len: got %0d cycles want %0d", n, INH + 1); else passed++;
        checks++; if (first_data !== INH) $display("FAIL start_bit_pos: got %0d want %0d", first_data, INH); else passed++;
        checks++; if (!st || got !== exp) $display("FAIL inhibit_frame: got %b want %b (started=%b)", got, exp, st); else passed++;
        checks++; if (exp_ack && done_cnt !== 1) $display("FAIL inhibit_done: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_frames;
        logic [7:0] tbl_d[5]   = '{8'hED, 8'h00, 8'h01, 8'h80, 8'hFF};
        bit         tbl_par[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 5; t++) begin
            int d0 = done_cnt, e0 = err_cnt;
            logic [9:0] got, exp;
            bit st, exp_ack;
            send(tbl_d[t], 1'b1);
            kbd(1'b1, got, st);
            wait_cycles(20);
            exp = exp_frame_q.pop_front();
            exp_ack = exp_ack_q.pop_front();
            checks++; if (!st) $display("FAIL frame_start_%h: no request-to-send seen", tbl_d[t]); else passed++;
            checks++; if (got !== exp) $display("FAIL frame_%h: got %b want %b", tbl_d[t], got, exp); else passed++;
            checks++; if (got[8] !== tbl_par[t]) $display("FAIL parity_%h: got %b want %b", tbl_d[t], got[8], tbl_par[t]); else passed++;
            checks++; if (done_cnt - d0 !== (exp_ack ? 1 : 0)) $display("FAIL done_%h: got %0d pulses want %0d", tbl_d[t], done_cnt - d0, exp_ack ? 1 : 0); else passed++;
            checks++; if (err_cnt - e0 !== (exp_ack ? 0 : 1)) $display("FAIL err_%h: got %0d pulses want %0d", tbl_d[t], err_cnt - e0, exp_ack ? 0 : 1); else passed++;
            checks++; if (tx_ready !== 1'b1) $display("FAIL ready_after_%h: got %b want 1", tbl_d[t], tx_ready); else passed++;
        end
    endtask

    task automatic test_nack;
        int d0 = done_cnt, e0 = err_cnt;
        logic [9:0] got, exp;
        bit st, exp_ack;
        send(8'h5A, 1'b0);
        kbd(1'b0, got, st);
        wait_cycles(20);
        exp = exp_frame_q.pop_front();
        exp_ack = exp_ack_q.pop_front();
        checks++; if (!st || got !== exp) $display("FAIL nack_frame: got %b want %b", got, exp); else passed++;
        checks++; if (err_cnt - e0 !== (exp_ack ? 0 : 1)) $display("FAIL nack_err: got %0d pulses want 1", err_cnt - e0); else passed++;
        checks++; if (done_cnt - d0 !== 0) $display("FAIL nack_done: got %0d pulses want 0", done_cnt - d0); else passed++;
    endtask

    task automatic test_timeout;
        int d0 = done_cnt, e0 = err_cnt, k = 0, cnt = 0;
        send(8'h12, 1'b0);
        while (!(!ps2_clk_oe && ps2_data_oe) && k < INH + 100) begin
            @(negedge clk);
            k++;
        end
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) $display("FAIL tmo_release: clk_oe=%b data_oe=%b want 0/1", ps2_clk_oe, ps2_data_oe); else passed++;
        while (!tx_err && cnt < TMO + 10) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt !== TMO) $display("FAIL tmo_cycles: got %0d want %0d", cnt, TMO); else passed++;
        @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL tmo_lines: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); else passed++;
        checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) $display("FAIL tmo_pulses: err=%0d done=%0d want 1/0", err_cnt - e0, done_cnt - d0); else passed++;
        void'(exp_frame_q.pop_front());
        void'(exp_ack_q.pop_front());
    endtask

    task automatic test_busy_ignore;
        int o0;
        logic [9:0] got, exp;
        bit st, exp_ack;
        send(8'h96, 1'b1);
        wait_cycles(3);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        wait_cycles(3);
        tx_valid = 1'b0;
        kbd(1'b1, got, st);
        wait_cycles(20);
        exp = exp_frame_q.pop_front();
        exp_ack = exp_ack_q.pop_front();
        checks++; if (!st || got !== exp) $display("FAIL busy_frame: got %b want %b", got, exp); else passed++;
        o0 = oe_cycles;
        wait_cycles(INH + 50);
        checks++; if (oe_cycles - o0 !== 0) $display("FAIL busy_no_requeue: got %0d inhibit cycles want 0", oe_cycles - o0); else passed++;
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt, e0 = err_cnt, k = 0, o0;
        send(8'h2C, 1'b1);
        while (!(!ps2_clk_oe && ps2_data_oe) && k < INH + 100) begin
            @(negedge clk);
            k++;
        end
        wait_cycles(H);
        for (int i = 0; i < 5; i++) begin
            kbd_clk_low = 1'b1;
            wait_cycles(H);
            if (i < 4) begin
                kbd_clk_low = 1'b0;
                wait_cycles(H);
            end
        end
        checks++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_bit4: data_oe=%b want 1", ps2_data_oe); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL mid_reset_lines: clk_oe=%b data_oe=%b want 0/0", ps2_clk_oe, ps2_data_oe); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", tx_ready); else passed++;
        rst_n = 1'b1;
        kbd_clk_low = 1'b0;
        o0 = oe_cycles;
        wait_cycles(INH + 50);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) $display("FAIL mid_reset_pulses: done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0); else passed++;
        checks++; if (oe_cycles - o0 !== 0) $display("FAIL mid_reset_restart: got %0d inhibit cycles want 0", oe_cycles - o0); else passed++;
        void'(exp_frame_q.pop_front());
        void'(exp_ack_q.pop_front());
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_inhibit();
        test_frames();
        test_nack();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        checks++; if (both_cnt !== 0) $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt); else passed++;
        checks++; if (exp_frame_q.size() !== 0) $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_frame_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
